pattern_detector: RTL and testbench
===================================

PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 8: width of match_count.
REQ-003 Parameter RST_PATTERN, default 8'b10110101 zero-extended to MAX_LEN: pattern loaded at reset.
REQ-004 Parameter RST_LEN, default 8: pattern length loaded at reset.
REQ-005 Derived LEN_W = $clog2(MAX_LEN+1).
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 in_valid  in  1  in_bit is a sample this cycle.
REQ-009 in_bit  in  1  serial data bit.
REQ-010 cfg_load  in  1  one-cycle request to load cfg_pattern/cfg_len/cfg_overlap.
REQ-011 cfg_pattern  in  MAX_LEN  pattern; bit[len-1] is the first bit received, bit[0] the last.
REQ-012 cfg_len  in  LEN_W  pattern length.
REQ-013 cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-014 cnt_clr  in  1  synchronous clear of match_count.
REQ-015 detected  out  1  registered one-cycle pulse per match.
REQ-016 match_count  out  CNT_W  saturating count of matches.
REQ-017 cfg_err  out  1  registered one-cycle pulse on a rejected cfg_load.

Function
REQ-018 Block SHALL keep a MAX_LEN-bit history register, newest bit at bit[0], shifting only when in_valid=1.
REQ-019 Block SHALL keep a fill counter (0..MAX_LEN, saturating) of valid bits accepted since the last reset, config load or non-overlap match.
REQ-020 A match SHALL occur on a cycle with in_valid=1 when fill+1 >= len and the low len bits of {history, in_bit} equal the low len bits of the active pattern.
REQ-021 detected SHALL be 1 exactly in the cycle after the matching bit is sampled, otherwise 0 (latency 1 cycle).
REQ-022 In overlap mode, history and fill SHALL be unaffected by a match.
REQ-023 In non-overlap mode, fill SHALL be set to 0 on a match, so the next match needs len fresh bits.
REQ-024 cfg_load with 2 <= cfg_len <= MAX_LEN SHALL update pattern, len and overlap on that edge and clear fill to 0.
REQ-025 cfg_load with cfg_len < 2 or cfg_len > MAX_LEN SHALL leave configuration, history and fill unchanged and pulse cfg_err the next cycle.
REQ-026 When cfg_load and in_valid coincide, the in_bit SHALL be discarded, with no shift and no match.
REQ-027 Pattern bits above len-1 SHALL be ignored in comparison.
REQ-028 match_count SHALL increment by 1 per match and hold at 2^CNT_W-1 (no wrap).
REQ-029 When cnt_clr and a match coincide, match_count SHALL become 1.
REQ-030 With in_valid=0, no state other than detected/cfg_err deassertion SHALL change.

Reset
REQ-031 On reset_n=0: history=0, fill=0, detected=0, cfg_err=0, match_count=0, pattern=RST_PATTERN, len=RST_LEN, overlap=1.
REQ-032 Reset asserted mid-stream SHALL discard partial matches immediately; a pending detected pulse SHALL NOT appear.
REQ-033 With default parameters and no cfg_load, match behaviour SHALL equal the legacy 8-bit 10110101 overlapping detector, delayed by one cycle.

Structure
REQ-034 Package pattern_detector_pkg SHALL hold MAX_LEN default, RST_PATTERN, RST_LEN and the minimum legal length (2).
REQ-035 The saturating counter SHALL be a sub-module match_counter (ports: clk, reset_n, inc, clr, count).
REQ-036 Comparison and shift SHALL stay in pattern_detector; no internal FSM beyond fill counter.

Verification
REQ-037 Reset defaults, stream 1,0,1,1,0,1,0,1 (valid every cycle) -> detected pulses once, the cycle after bit 8; match_count=1.
REQ-038 Defaults, stream 10110101 then 10101 -> overlap=1: two pulses (after bits 8 and 13); after loading the same pattern with overlap=0: one pulse.
REQ-039 Load cfg_len=3, pattern 3'b110, stream 110110 with in_valid gapped every other cycle -> pulses after bits 3 and 6 only, none on idle cycles.
REQ-040 cfg_load with cfg_len=0 and with cfg_len=MAX_LEN+1 -> cfg_err pulse each time, default pattern still matches 10110101.
REQ-041 CNT_W=2, 5 matches -> match_count 1,2,3,3,3; cnt_clr coincident with the 6th match -> 1.
REQ-042 reset_n pulsed low after 7 bits of 10110101, then 1 -> no detected; the full 8-bit sequence afterwards -> one pulse.

Source files
------------

// File: rtl/pattern_detector_pkg.sv
// Shared defaults for the configurable serial pattern detector.
package pattern_detector_pkg;

  localparam int         MAX_LEN_DEF     = 8;
  localparam logic [7:0] RST_PATTERN_DEF = 8'b1011_0101;
  localparam int         RST_LEN_DEF     = 8;
  localparam int         MIN_LEN         = 2;

endpackage : pattern_detector_pkg

// File: rtl/match_counter.sv
// Saturating match counter; a clear coincident with an increment yields 1.
module match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: next-state logic assigns its default first, so no latch can be inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? CNT_ONE : '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : match_counter

// File: rtl/pattern_detector.sv
// Serial pattern detector with runtime-loadable pattern, length and overlap mode.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int                 MAX_LEN     = MAX_LEN_DEF,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(RST_PATTERN_DEF),
  parameter int                 RST_LEN     = RST_LEN_DEF,
  localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] MAX_FILL  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] RST_LEN_L = LEN_W'(RST_LEN);
  localparam logic [LEN_W-1:0] FILL_ONE  = LEN_W'(1);
  localparam logic [LEN_W:0]   WIDE_ONE  = (LEN_W + 1)'(1);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               overlap_q, overlap_d;
  logic               det_q, cfg_err_q;

  logic [MAX_LEN:0]   len_mask;
  logic               len_reached;
  logic               match;
  logic               cfg_ok;

  // The window {history, in_bit} is one bit wider than the pattern; the mask
  // keeps only the low len bits, so the oldest history bit never decides a match.
  always_comb begin
    len_mask    = ~({(MAX_LEN + 1){1'b1}} << len_q);
    len_reached = ({1'b0, fill_q} + WIDE_ONE) >= {1'b0, len_q};
    match       = in_valid && !cfg_load && len_reached &&
                  ((({hist_q, in_bit} ^ {1'b0, pattern_q}) & len_mask) == '0);
    cfg_ok      = (cfg_len >= MIN_LEN_L) && (cfg_len <= MAX_FILL);
  end

  always_comb begin
    hist_d    = hist_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    fill_d    = fill_q;
    overlap_d = overlap_q;
    if (cfg_load) begin
      // A coincident sample is dropped; a rejected load touches nothing.
      if (cfg_ok) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        fill_d    = '0;
      end
    end else if (in_valid) begin
      hist_d = {hist_q[MAX_LEN-2:0], in_bit};
      if (match && !overlap_q) begin
        fill_d = '0;
      end else if (fill_q != MAX_FILL) begin
        fill_d = fill_q + FILL_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q    <= '0;
      pattern_q <= RST_PATTERN;
      len_q     <= RST_LEN_L;
      fill_q    <= '0;
      overlap_q <= 1'b1;
      det_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      overlap_q <= overlap_d;
      det_q     <= match;
      cfg_err_q <= cfg_load && !cfg_ok;
    end
  end

  match_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (match),
    .clr     (cnt_clr),
    .count   (match_count)
  );

  assign detected = det_q;
  assign cfg_err  = cfg_err_q;

endmodule : pattern_detector

// File: tb/tb_pattern_detector.sv
// Self-checking bench: directed tables and sequences plus random traffic against a bit-queue model.
module tb_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_bit = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cnt_clr = 1'b0;

  logic               detected, cfg_err, detected2, cfg_err2;
  logic [7:0]         match_count;
  logic [1:0]         match_count2;

  always #5 clk = ~clk;

  pattern_detector u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .detected    (detected),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  pattern_detector #(.CNT_W(2)) u_dut_c2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .detected    (detected2),
    .match_count (match_count2),
    .cfg_err     (cfg_err2)
  );

  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;

  // Reference model: the raw accepted bit stream plus a count of fresh bits.
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_bits[$];
  int         m_fresh;
  bit         m_det, m_err;
  int         m_cnt8, m_cnt2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pat = 8'b1011_0101; m_len = 8; m_ovl = 1'b1;
    m_bits.delete(); m_fresh = 0;
    m_det = 1'b0; m_err = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  task automatic model_step();
    bit hit;
    hit = 1'b0;
    m_err = 1'b0;
    if (cfg_load) begin
      if (int'(cfg_len) >= 2 && int'(cfg_len) <= MAX_LEN) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; m_fresh = 0;
      end else begin
        m_err = 1'b1;
      end
    end else if (in_valid) begin
      m_bits.push_back(in_bit);
      if (m_bits.size() > 64) void'(m_bits.pop_front());
      if (m_fresh + 1 >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 1'b0;
      end
      m_fresh++;
      if (hit && !m_ovl) m_fresh = 0;
    end
    m_det = hit;
    if (cnt_clr) begin
      m_cnt8 = hit ? 1 : 0;
      m_cnt2 = hit ? 1 : 0;
    end else if (hit) begin
      m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
    check("det", detected, m_det);
    check("err", cfg_err, m_err);
    check("cnt", match_count, m_cnt8);
    check("det2", detected2, m_det);
    check("err2", cfg_err2, m_err);
    check("cnt2", match_count2, m_cnt2);
    if (detected) pulses++;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      in_valid = 1'b1;
      in_bit   = bits[i];
      tick();
      if (gap) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [LEN_W-1:0] len, input bit ovl);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    in_valid    = 1'b1;
    in_bit      = 1'b1;
    tick();
    in_valid    = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #2;
    check("rst_det", detected, 0);
    check("rst_err", cfg_err, 0);
    check("rst_cnt", match_count, 0);
    check("rst_cnt2", match_count2, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic v;
    logic b;
    logic det;
    int   cnt;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[10];
    int   exp_c2[4];
    logic [1:0] pre;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1};
    exp_c2 = '{2, 3, 3, 3};

    // Default pattern, single match, table-driven.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].v;
      in_bit   = tbl[i].b;
      tick();
      check($sformatf("tbl_det[%0d]", i), detected, tbl[i].det);
      check($sformatf("tbl_cnt[%0d]", i), match_count, tbl[i].cnt);
    end
    in_valid = 1'b0;

    // Overlap vs non-overlap on 10110101 + 10101.
    do_reset();
    pulses = 0;
    send_bits(32'b1_0110_1011_0101, 13, 1'b0);
    check("ovl_pulses", pulses, 2);
    load_cfg(8'b1011_0101, 4'd8, 1'b0);
    pulses = 0;
    send_bits(32'b1_0110_1011_0101, 13, 1'b0);
    check("novl_pulses", pulses, 1);

    // Short pattern with junk upper bits, gapped input.
    do_reset();
    load_cfg(8'b1010_1110, 4'd3, 1'b1);
    pulses = 0;
    send_bits(32'b110110, 6, 1'b1);
    check("len3_pulses", pulses, 2);

    // Illegal lengths rejected, default pattern kept.
    do_reset();
    load_cfg(8'b0000_0011, 4'd0, 1'b0);
    check("err_len0", cfg_err, 1);
    load_cfg(8'b0000_0011, 4'd9, 1'b0);
    check("err_len9", cfg_err, 1);
    tick();
    check("err_clear", cfg_err, 0);
    pulses = 0;
    send_bits(32'b1011_0101, 8, 1'b0);
    check("err_keep_pulses", pulses, 1);

    // 2-bit counter saturation and clear coincident with a match.
    do_reset();
    send_bits(32'b1011_0101, 8, 1'b0);
    check("c2_1", match_count2, 1);
    for (int k = 0; k < 4; k++) begin
      send_bits(32'b10101, 5, 1'b0);
      check($sformatf("c2_%0d", k + 2), match_count2, exp_c2[k]);
    end
    send_bits(32'b1010, 4, 1'b0);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    cnt_clr  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("c2_clr_hit", match_count2, 1);
    check("c8_clr_hit", match_count, 1);

    // Reset mid-stream discards the partial match.
    do_reset();
    pulses = 0;
    send_bits(32'b101_1010, 7, 1'b0);
    reset_n = 1'b0;
    model_reset();
    #2;
    check("mid_rst_det", detected, 0);
    @(negedge clk);
    reset_n = 1'b1;
    send_bits(32'b1, 1, 1'b0);
    check("mid_rst_pulses", pulses, 0);
    send_bits(32'b1011_0101, 8, 1'b0);
    check("post_rst_pulses", pulses, 1);

    // Reset during the matching edge suppresses the pending pulse.
    do_reset();
    send_bits(32'b101_1010, 7, 1'b0);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    reset_n  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("pend_det", detected, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic with occasional reconfiguration and clears.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        cfg_load    = 1'b1;
        cfg_len     = ($urandom_range(0, 9) < 7) ? LEN_W'($urandom_range(2, 4))
                                                 : LEN_W'($urandom_range(0, 9));
        cfg_pattern = 8'($urandom);
        cfg_overlap = 1'($urandom_range(0, 1));
      end
      pre      = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 9) < 7);
      in_bit   = pre[0];
      cnt_clr  = ($urandom_range(0, 99) == 0);
      tick();
    end
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pattern_detector
